// File: rtl/ram_dp_param.sv
// Dual-port data RAM: port A read/write with byte enables, port B read-only scan.
// A clear engine fills the array with FILL after reset or on request; err latches out-of-range accesses.
module ram_dp_param #(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 328,
  parameter int                ADDR_W         = 32,
  parameter int                READ_MODE      = 0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] FILL           = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   busy,
  input  logic                   a_en,
  input  logic                   a_we,
  input  logic [DATA_W/8-1:0]    a_be,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  output logic [DATA_W-1:0]      a_rdata,
  output logic                   a_rvalid,
  input  logic                   b_en,
  input  logic [ADDR_W-1:0]      b_addr,
  output logic [DATA_W-1:0]      b_rdata,
  output logic                   b_rvalid,
  output logic                   err
);

  localparam int                BE_W     = DATA_W / 8;
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              a_rvalid_q, b_rvalid_q, err_q;

  logic              a_in, b_in, a_acc, b_acc, a_wr, a_rd;
  logic [IDX_W-1:0]  a_idx, b_idx;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Clear FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ptr counts to DEPTH-1 explicitly so non-power-of-two depths never wrap
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        if (ptr_q == LAST_IDX) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_CLEAR);
    clr_we = (state_q == S_CLEAR) & ~reset;
  end

  assign a_in  = (a_addr < DEPTH_A);
  assign b_in  = (b_addr < DEPTH_A);
  assign a_idx = a_addr[IDX_W-1:0];
  assign b_idx = b_addr[IDX_W-1:0];
  assign a_acc = a_en & ~busy & ~reset;
  assign b_acc = b_en & ~busy & ~reset;
  assign a_wr  = a_acc & a_we & a_in;
  assign a_rd  = a_acc & ~a_we;

  // Out-of-range reads return zero; a same-cycle A write is visible to B only in write-first mode
  always_comb begin
    a_rdata_d = '0;
    b_rdata_d = '0;
    if (a_in) a_rdata_d = mem_q[a_idx];
    if (b_in) begin
      if ((READ_MODE == 1) && a_wr && (a_idx == b_idx)) begin
        b_rdata_d = merge_bytes(mem_q[b_idx], a_wdata, a_be);
      end else begin
        b_rdata_d = mem_q[b_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[ptr_q] <= FILL;
    end else if (a_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_be[i]) mem_q[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // Read-data stage: rdata holds until the next accepted read on its port
  always_ff @(posedge clock) begin
    if (reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_acc;
      if (a_rd)  a_rdata_q <= a_rdata_d;
      if (b_acc) b_rdata_q <= b_rdata_d;
      if ((a_acc & ~a_in) | (b_acc & ~b_in)) err_q <= 1'b1;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rdata  = b_rdata_q;
  assign b_rvalid = b_rvalid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: a 32x328 read-first instance and a 16x5 write-first instance,
// randomized traffic against an array model, with a queue-based scoreboard per read port.
module tb_ram_dp_param;

  localparam int D0 = 328;
  localparam int D1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        rst0 = 1'b0, clr0 = 1'b0, aen0 = 1'b0, awe0 = 1'b0, ben0 = 1'b0;
  logic [3:0]  abe0 = '0;
  logic [31:0] aaddr0 = '0, awd0 = '0, baddr0 = '0;
  logic        busy0, arv0, brv0, err0;
  logic [31:0] ard0, brd0;

  logic        rst1 = 1'b0, clr1 = 1'b0, aen1 = 1'b0, awe1 = 1'b0, ben1 = 1'b0;
  logic [1:0]  abe1 = '0;
  logic [7:0]  aaddr1 = '0, baddr1 = '0;
  logic [15:0] awd1 = '0;
  logic        busy1, arv1, brv1, err1;
  logic [15:0] ard1, brd1;

  ram_dp_param #(.DATA_W(32), .DEPTH(D0), .ADDR_W(32), .READ_MODE(0), .CLEAR_ON_RESET(1),
                 .FILL(32'h0)) dut0 (
    .clock(clk), .reset(rst0), .clear_req(clr0), .busy(busy0),
    .a_en(aen0), .a_we(awe0), .a_be(abe0), .a_addr(aaddr0), .a_wdata(awd0),
    .a_rdata(ard0), .a_rvalid(arv0),
    .b_en(ben0), .b_addr(baddr0), .b_rdata(brd0), .b_rvalid(brv0), .err(err0));

  ram_dp_param #(.DATA_W(16), .DEPTH(D1), .ADDR_W(8), .READ_MODE(1), .CLEAR_ON_RESET(1),
                 .FILL(16'h0)) dut1 (
    .clock(clk), .reset(rst1), .clear_req(clr1), .busy(busy1),
    .a_en(aen1), .a_we(awe1), .a_be(abe1), .a_addr(aaddr1), .a_wdata(awd1),
    .a_rdata(ard1), .a_rvalid(arv1),
    .b_en(ben1), .b_addr(baddr1), .b_rdata(brd1), .b_rvalid(brv1), .err(err1));

  // Reference model: word arrays plus the expected state after the coming edge (_n)
  // and after the last edge (registered copies the monitor compares against).
  typedef struct { logic [31:0] data; int unsigned cyc; } exp_t;
  exp_t qa0[$], qb0[$], qa1[$], qb1[$];

  logic [31:0] mdl [2][D0];
  int          rem_n [2] = '{0, 0};
  int          rem   [2] = '{0, 0};
  bit          err_n [2] = '{0, 0};
  bit          err_q [2] = '{0, 0};
  bit          chk_n [2] = '{0, 0};
  bit          chk   [2] = '{0, 0};
  logic [31:0] ah_n  [2] = '{0, 0};
  logic [31:0] ah    [2] = '{0, 0};
  logic [31:0] bh_n  [2] = '{0, 0};
  logic [31:0] bh    [2] = '{0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rem[d]   <= rem_n[d];
      err_q[d] <= err_n[d];
      chk[d]   <= chk_n[d];
      ah[d]    <= ah_n[d];
      bh[d]    <= bh_n[d];
    end
  end

  task automatic fail(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_fail++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // One clock of stimulus for instance d; the model decides what the RAM must do at the edge.
  task automatic op(input int d, input bit r, input bit clr, input bit aen, input bit awe,
                    input logic [3:0] abe, input int unsigned aa, input logic [31:0] awd,
                    input bit ben, input int unsigned ba);
    int          dep;
    logic [31:0] wmask, oldw, neww, bres, ares;
    logic [3:0]  be;
    bit          ain, bin;
    dep   = (d == 0) ? D0 : D1;
    wmask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    be    = abe & ((d == 0) ? 4'b1111 : 4'b0011);
    if (d == 0) begin
      rst0 = r; clr0 = clr; aen0 = aen; awe0 = awe; abe0 = abe;
      aaddr0 = aa; awd0 = awd; ben0 = ben; baddr0 = ba;
    end else begin
      rst1 = r; clr1 = clr; aen1 = aen; awe1 = awe; abe1 = abe[1:0];
      aaddr1 = aa[7:0]; awd1 = awd[15:0]; ben1 = ben; baddr1 = ba[7:0];
    end
    if (r) begin
      rem_n[d] = dep;
      err_n[d] = 1'b0;
      chk_n[d] = 1'b1;
      ah_n[d]  = '0;
      bh_n[d]  = '0;
      for (int i = 0; i < dep; i++) mdl[d][i] = '0;
    end else begin
      rem_n[d] = (rem[d] > 0) ? rem[d] - 1 : 0;
      if (rem[d] == 0) begin
        ain  = (aa < dep);
        bin  = (ba < dep);
        oldw = ain ? mdl[d][aa] : '0;
        neww = oldw;
        for (int i = 0; i < 4; i++) if (be[i]) neww[8*i +: 8] = awd[8*i +: 8];
        neww = neww & wmask;
        if (ben) begin
          bres = '0;
          if (bin) bres = ((d == 1) && aen && awe && ain && (aa == ba)) ? neww : mdl[d][ba];
          else err_n[d] = 1'b1;
          if (d == 0) qb0.push_back('{data: bres, cyc: cyc + 1});
          else        qb1.push_back('{data: bres, cyc: cyc + 1});
          bh_n[d] = bres;
        end
        if (aen) begin
          if (!ain) err_n[d] = 1'b1;
          if (awe) begin
            if (ain) mdl[d][aa] = neww;
          end else begin
            ares = oldw;
            if (d == 0) qa0.push_back('{data: ares, cyc: cyc + 1});
            else        qa1.push_back('{data: ares, cyc: cyc + 1});
            ah_n[d] = ares;
          end
        end
        if (clr) begin
          rem_n[d] = dep;
          for (int i = 0; i < dep; i++) mdl[d][i] = '0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) op(d, 0, 0, 0, 0, 4'h0, 0, 32'h0, 0, 0);
  endtask

  // Keep both ports strobing while the clear runs; every request must be dropped.
  task automatic hammer_while_busy(input int d);
    int unsigned dep;
    dep = (d == 0) ? D0 : D1;
    for (int i = 0; i < 2000 && rem[d] != 0; i++) begin
      op(d, 0, 0, 1, (i % 37) == 3, 4'hF, $urandom_range(0, dep - 1), $urandom, 1,
         $urandom_range(0, dep - 1));
    end
  endtask

  task automatic random_run(input int d, input int n, input int unsigned amax);
    bit          rclr, raen, rawe, rben;
    logic [3:0]  rbe;
    int unsigned ra, rb;
    for (int i = 0; i < n; i++) begin
      rclr = ($urandom_range(0, 199) == 0);
      raen = 1'($urandom_range(0, 1));
      rawe = 1'($urandom_range(0, 1));
      rben = 1'($urandom_range(0, 1));
      rbe  = 4'($urandom_range(0, 15));
      ra   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, amax);
      rb   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, amax);
      if (ra > amax) ra = amax;
      if (rb > amax) rb = amax;
      op(d, 0, rclr, raen, rawe, rbe, ra, $urandom, rben, rb);
    end
  endtask

  task automatic seq0();
    op(0, 1, 0, 0, 0, 4'h0, 0, 32'h0, 0, 0);
    op(0, 1, 0, 0, 0, 4'h0, 0, 32'h0, 0, 0);
    hammer_while_busy(0);
    op(0, 0, 0, 1, 0, 4'h0, 0,   32'h0, 0, 0);
    op(0, 0, 0, 1, 0, 4'h0, 163, 32'h0, 0, 0);
    op(0, 0, 0, 1, 0, 4'h0, 327, 32'h0, 1, 327);
    op(0, 0, 0, 1, 1, 4'hF, 5, 32'hDEADBEEF, 0, 0);
    op(0, 0, 0, 1, 1, 4'b0101, 5, 32'h11223344, 0, 0);
    op(0, 0, 0, 1, 0, 4'h0, 5, 32'h0, 1, 5);
    op(0, 0, 0, 1, 1, 4'hF, 10, 32'hCAFEF00D, 1, 10);
    op(0, 0, 0, 1, 0, 4'h0, 10, 32'h0, 1, 10);
    op(0, 0, 0, 1, 1, 4'b0000, 10, 32'h55555555, 0, 0);
    op(0, 0, 0, 1, 0, 4'h0, 10, 32'h0, 0, 0);
    random_run(0, 600, D0 - 1);
    idle(0, 2);
    hammer_while_busy(0);
    op(0, 0, 0, 1, 1, 4'hF, 328, 32'hA5A5A5A5, 0, 0);
    op(0, 0, 0, 1, 0, 4'h0, 328, 32'h0, 1, 400);
    idle(0, 20);
    op(0, 0, 0, 1, 0, 4'h0, 0, 32'h0, 1, 5);
    op(0, 0, 1, 1, 0, 4'h0, 3, 32'h0, 1, 4);
    for (int i = 0; i < 99; i++) op(0, 0, 0, 1, 0, 4'h0, i, 32'h0, 1, i);
    op(0, 1, 0, 1, 0, 4'h0, 7, 32'h0, 1, 7);
    hammer_while_busy(0);
    for (int i = 0; i < D0; i++) op(0, 0, 0, 1, 0, 4'h0, i, 32'h0, 1, D0 - 1 - i);
    idle(0, 3);
  endtask

  task automatic seq1();
    op(1, 1, 0, 0, 0, 4'h0, 0, 32'h0, 0, 0);
    hammer_while_busy(1);
    op(1, 0, 0, 1, 1, 4'b01, 4, 32'h0000A5C3, 0, 0);
    op(1, 0, 0, 1, 1, 4'b10, 4, 32'h00007E11, 0, 0);
    op(1, 0, 0, 1, 0, 4'h0, 4, 32'h0, 1, 4);
    op(1, 0, 0, 1, 1, 4'b11, 2, 32'h0000BEEF, 1, 2);
    op(1, 0, 0, 1, 1, 4'b01, 2, 32'h00001234, 1, 2);
    op(1, 0, 0, 1, 0, 4'h0, 2, 32'h0, 0, 0);
    op(1, 0, 0, 1, 0, 4'h0, 1, 32'h0, 1, 3);
    op(1, 1, 0, 1, 0, 4'h0, 1, 32'h0, 1, 3);
    hammer_while_busy(1);
    op(1, 0, 0, 1, 1, 4'h3, 3, 32'h00009999, 0, 0);
    op(1, 0, 0, 1, 0, 4'h0, 5, 32'h0, 0, 0);
    idle(1, 4);
    op(1, 0, 1, 0, 0, 4'h0, 0, 32'h0, 0, 0);
    hammer_while_busy(1);
    op(1, 0, 0, 1, 0, 4'h0, 3, 32'h0, 1, 4);
    random_run(1, 300, D1 + 1);
    idle(1, 3);
  endtask

  task automatic chk_rd(input string nm, input logic vld, input logic [31:0] dat,
                        input logic [31:0] hold, input bit have, input exp_t e, output bit pop);
    pop = 1'b0;
    n_cmp++;
    if (have && e.cyc <= cyc) begin
      pop = 1'b1;
      if (vld !== 1'b1)        fail({nm, "_rvalid_missing"}, {31'b0, vld}, 32'd1);
      else if (dat !== e.data) fail({nm, "_rdata"}, dat, e.data);
    end else if (vld !== 1'b0) begin
      fail({nm, "_rvalid_unexpected"}, {31'b0, vld}, 32'd0);
    end else if (dat !== hold) begin
      fail({nm, "_rdata_hold"}, dat, hold);
    end
  endtask

  exp_t e_m;
  bit   pop_m;

  always @(negedge clk) begin
    if (chk[0]) begin
      n_cmp++;
      if (busy0 !== (rem[0] != 0)) fail("busy0", {31'b0, busy0}, 32'(rem[0] != 0));
      n_cmp++;
      if (err0 !== err_q[0]) fail("err0", {31'b0, err0}, 32'(err_q[0]));
      e_m = '{data: 32'h0, cyc: 0};
      if (qa0.size() > 0) e_m = qa0[0];
      chk_rd("a0", arv0, ard0, ah[0], qa0.size() > 0, e_m, pop_m);
      if (pop_m) void'(qa0.pop_front());
      e_m = '{data: 32'h0, cyc: 0};
      if (qb0.size() > 0) e_m = qb0[0];
      chk_rd("b0", brv0, brd0, bh[0], qb0.size() > 0, e_m, pop_m);
      if (pop_m) void'(qb0.pop_front());
    end
    if (chk[1]) begin
      n_cmp++;
      if (busy1 !== (rem[1] != 0)) fail("busy1", {31'b0, busy1}, 32'(rem[1] != 0));
      n_cmp++;
      if (err1 !== err_q[1]) fail("err1", {31'b0, err1}, 32'(err_q[1]));
      e_m = '{data: 32'h0, cyc: 0};
      if (qa1.size() > 0) e_m = qa1[0];
      chk_rd("a1", arv1, {16'h0, ard1}, ah[1], qa1.size() > 0, e_m, pop_m);
      if (pop_m) void'(qa1.pop_front());
      e_m = '{data: 32'h0, cyc: 0};
      if (qb1.size() > 0) e_m = qb1[0];
      chk_rd("b1", brv1, {16'h0, brd1}, bh[1], qb1.size() > 0, e_m, pop_m);
      if (pop_m) void'(qb1.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      seq0();
      seq1();
    join
    @(negedge clk);
    #1;
    n_cmp++;
    if (qa0.size() != 0) fail("a0_pending_reads", qa0.size(), 0);
    n_cmp++;
    if (qb0.size() != 0) fail("b0_pending_reads", qb0.size(), 0);
    n_cmp++;
    if (qa1.size() != 0) fail("a1_pending_reads", qa1.size(), 0);
    n_cmp++;
    if (qb1.size() != 0) fail("b1_pending_reads", qb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised dual-port data RAM that replaces the fixed 32x328 data memory in the processor datapath. Port A is the CPU load/store port (read/write, byte enables). Port B is a read-only scan port for the display/debug path, replacing the full-array dump output. A built-in clear engine zero-fills the array after reset or on request, and a sticky error flag catches out-of-range accesses.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 328, number of words
- ADDR_W, 32, address width; addresses >= DEPTH are out of range
- READ_MODE, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RESET, 1, 1 = run the clear engine after every reset
- FILL, 0, DATA_W-bit value written by the clear engine
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  single-cycle request to zero-fill the array; ignored while busy
- busy  out  1  high while the clear engine runs
- a_en  in  1  port A access strobe
- a_we  in  1  port A write (1) or read (0)
- a_be  in  DATA_W/8  port A byte enables; bit i covers data[8i+7:8i]
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data
- a_rvalid  out  1  port A read-data-valid pulse
- b_en  in  1  port B read strobe
- b_addr  in  ADDR_W  port B word address
- b_rdata  out  DATA_W  port B read data
- b_rvalid  out  1  port B read-data-valid pulse
- err  out  1  sticky out-of-range flag

## Operation
- Storage: DEPTH x DATA_W array. No initialisation file; contents are defined only after a clear.
- Clear FSM states:
  - IDLE to CLEAR on clear_req, or on reset when CLEAR_ON_RESET=1.
  - In CLEAR, write FILL to word ptr each cycle and increment ptr.
  - CLEAR to IDLE after writing word DEPTH-1.
- While busy=1:
  - a_en and b_en are ignored; no writes, no rvalid.
  - Requests are dropped, not queued.
- Port A write (a_en & a_we, in range): update only the bytes with a_be set. a_be=0 is a legal no-op. No rvalid.
- Port A read (a_en & ~a_we): word returned on a_rdata. a_be is ignored.
- Port B read: word returned on b_rdata. Port B never writes.
- Out-of-range access (addr >= DEPTH) on either port:
  - Writes are suppressed; reads return 0 with rvalid still pulsed.
  - err is set and stays set until reset.
- Collision (A writes and B reads the same in-range address in the same cycle):
  - READ_MODE=0: b_rdata returns the old word.
  - READ_MODE=1: b_rdata returns the merged new word, with byte enables applied.
- Simultaneous clear_req and port access in IDLE: the access completes that cycle; clearing starts next cycle.
- a_rdata and b_rdata hold their last value until the next valid read on that port.

## Timing
- Reset values: a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, err=0, ptr=0.
- busy during reset: 1 if CLEAR_ON_RESET=1, else 0.
- Read latency is 1 cycle: strobe sampled at edge N; data and rvalid appear after edge N+1; rvalid stays high for one cycle.
- Back-to-back reads on every cycle are supported, giving full throughput per port.
- Write commits at the sampling edge. A port A read of the same address on the next cycle returns the new data.
- Clear duration is exactly DEPTH cycles:
  - After reset deasserts at edge R, busy falls after edge R+DEPTH.
  - After clear_req is sampled at edge C, busy rises after C and falls after C+DEPTH.
- Reset asserted mid-clear restarts the clear from ptr=0. Reset mid-read forces rvalid=0 next cycle.
- ptr does not wrap: it is compared to DEPTH-1, and DEPTH need not be a power of two.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=328 -> busy=1 for 328 cycles; then A-reads of addresses 0, 163 and 327 return 0x00000000 with a_rvalid one cycle after each strobe.
- A-write 0xDEADBEEF to addr 5 with a_be=4'b1111, then a_be=4'b0101 with data 0x11223344 -> A-read of addr 5 returns 0xDE22BE44.
- Same-cycle A-write 0xCAFEF00D and B-read at addr 10, where the old word is 0 -> b_rdata=0x00000000 with READ_MODE=0, and 0xCAFEF00D with READ_MODE=1.
- A-write to addr 328, then B-read of addr 400 -> memory unchanged, b_rdata=0, b_rvalid=1, err=1 and still 1 after 20 idle cycles.
- clear_req mid-run, with a_en held high during busy and reset pulsed at clear cycle 100 -> no rvalid while busy; busy falls exactly 328 cycles after reset deasserts; all words read back 0.
- DATA_W=16, DEPTH=5, READ_MODE=1 -> clear takes 5 cycles; a byte-enable write to addr 4 reads back correctly; addr 5 sets err.
